// File: rtl/ws2812b_rx.sv
// ws2812b_rx -- single-wire WS2812B NRZ receiver and one-pixel pass-through model.
//
// Samples the LED data line, measures each high pulse and classifies it as a
// 0 or 1 bit. Bits are assembled MSB-first into 24-bit GRB words. A long low
// gap ends the frame and is reported as a latch event. The first word of every
// frame is absorbed; later words are forwarded on fwd, like a real pixel.
//
// Ports:
//   clk    in   1   clock (64 MHz project clock assumed by the defaults)
//   reset  in   1   asynchronous, active-high reset
//   din    in   1   asynchronous LED data line
//   data   out  24  last complete word {G,R,B}, first received bit in data[23]
//   valid  out  1   one-cycle pulse when data is updated
//   latch  out  1   one-cycle pulse when a gap ends a frame holding >= 1 word
//   err    out  1   one-cycle pulse on a malformed stream
//   busy   out  1   frame in progress (first accepted bit until the gap)
//   fwd    out  1   pass-through line: low during the first word, then s_din
//
// state | meaning
// ------+------------------------------------------------------------------
// SYNC  | after reset/stuck-high error; ignore everything until a full gap
// IDLE  | line quiet between frames; wait for a rising edge
// HIGH  | measuring a high pulse
// LOW   | between pulses inside a frame; watch for next pulse or the gap

module ws2812b_rx #(
  parameter int MIN_HIGH     = 8,
  parameter int BIT_THRESH   = 38,
  parameter int MAX_HIGH     = 100,
  parameter int RESET_CYCLES = 3200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] data,
  output logic        valid,
  output logic        latch,
  output logic        err,
  output logic        busy,
  output logic        fwd
);

  localparam logic [6:0]  MIN_L  = 7'(MIN_HIGH);
  localparam logic [6:0]  THR_L  = 7'(BIT_THRESH);
  localparam logic [6:0]  MAX_L  = 7'(MAX_HIGH);
  localparam logic [11:0] RC_L   = 12'(RESET_CYCLES);
  localparam logic [11:0] RC_M1  = 12'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t      state, state_n;

  logic        s_meta, s_din, s_prev;
  logic        rise, fall;
  logic [6:0]  hcnt;
  logic [11:0] lcnt;
  logic        gap_hit, over_high;

  logic [23:0] sh, sh_n;
  logic [4:0]  bcnt, bcnt_n;
  logic        got_word, got_n;
  logic        busy_n, latch_n, err_n;
  logic        word_done, done_n;

  // input synchronizer plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b0;
      s_din  <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= din;
      s_din  <= s_meta;
      s_prev <= s_din;
    end
  end

  assign rise = s_din & ~s_prev;
  assign fall = ~s_din & s_prev;

  // hcnt is loaded with 1 on the first high sample, so at the falling edge it
  // holds the number of high samples, i.e. the measured pulse width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
    end else if (rise) begin
      hcnt <= 7'd1;
    end else if (s_din && hcnt != 7'h7f) begin
      hcnt <= hcnt + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcnt <= '0;
    end else if (rise) begin
      lcnt <= '0;
    end else if (!s_din && lcnt != RC_L) begin
      lcnt <= lcnt + 12'd1;
    end
  end

  // Both events fire on the edge where the counter would step to its limit,
  // so the registered outputs line up with that edge.
  assign gap_hit   = ~s_din & (lcnt >= RC_M1);
  assign over_high = s_din & (hcnt >= MAX_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    bcnt_n  = bcnt;
    got_n   = got_word;
    busy_n  = busy;
    latch_n = 1'b0;
    err_n   = 1'b0;
    done_n  = 1'b0;

    case (state)
      SYNC: begin
        if (gap_hit) begin
          state_n = IDLE;
        end
      end

      IDLE: begin
        if (rise) begin
          state_n = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          state_n = LOW;
          // widths below MIN_HIGH are glitches: no bit, no error
          if (hcnt >= MIN_L && hcnt <= MAX_L) begin
            sh_n   = {sh[22:0], (hcnt > THR_L)};
            busy_n = 1'b1;
            if (bcnt == 5'd23) begin
              bcnt_n = '0;
              got_n  = 1'b1;
              done_n = 1'b1;
            end else begin
              bcnt_n = bcnt + 5'd1;
            end
          end
        end else if (over_high) begin
          err_n   = 1'b1;
          sh_n    = '0;
          bcnt_n  = '0;
          busy_n  = 1'b0;
          got_n   = 1'b0;
          state_n = SYNC;
        end
      end

      LOW: begin
        if (rise) begin
          state_n = HIGH;
        end else if (gap_hit) begin
          if (bcnt == 5'd0) begin
            latch_n = got_word;
          end else begin
            err_n = 1'b1;
          end
          sh_n    = '0;
          bcnt_n  = '0;
          busy_n  = 1'b0;
          got_n   = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh        <= '0;
      bcnt      <= '0;
      got_word  <= 1'b0;
      busy      <= 1'b0;
      latch     <= 1'b0;
      err       <= 1'b0;
      word_done <= 1'b0;
    end else begin
      sh        <= sh_n;
      bcnt      <= bcnt_n;
      got_word  <= got_n;
      busy      <= busy_n;
      latch     <= latch_n;
      err       <= err_n;
      word_done <= done_n;
    end
  end

  // Output word stage. sh still holds the completed word here: the next bit
  // cannot be shifted in until at least one more full pulse has been seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= word_done;
      if (word_done) begin
        data <= sh;
      end
    end
  end

  assign fwd = s_din & got_word;

endmodule

// File: tb/tb_ws2812b_rx.sv
module tb_ws2812b_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] data;
  logic        valid, latch, err, busy, fwd;

  ws2812b_rx dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .data  (data),
    .valid (valid),
    .latch (latch),
    .err   (err),
    .busy  (busy),
    .fwd   (fwd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] exp_q[$];
  logic [23:0] exp_word;
  int valid_cnt = 0, latch_cnt = 0, err_cnt = 0;
  int valid_cyc = 0, latch_cyc = 0, err_cyc = 0;
  int last_fall_cyc = 0, last_rise_cyc = 0;

  logic din_d1 = 1'b0, din_d2 = 1'b0;
  always @(posedge clk) begin
    din_d1 <= din;
    din_d2 <= din_d1;
  end
  bit fwd_mon = 1'b0, fwd_phase = 1'b0;
  int fwd_bad = 0, fwd_hi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // output monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!reset) begin
      if (valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL valid_unexpected observed=%0h expected=no_word", data);
        end else begin
          exp_word = exp_q.pop_front();
          chk("data", data, exp_word);
        end
      end
      if (latch) begin
        latch_cnt++;
        latch_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (valid && latch) begin
        checks++;
        errors++;
        $error("FAIL valid_latch_overlap observed=1 expected=0");
      end
      if (fwd_mon) begin
        if (fwd !== (fwd_phase ? din_d2 : 1'b0)) fwd_bad++;
        if (fwd) fwd_hi++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int lo);
    din = 1'b1;
    last_rise_cyc = cyc;
    tick(h);
    din = 1'b0;
    last_fall_cyc = cyc;
    tick(lo);
  endtask

  task automatic send_word(input logic [23:0] w, input int h0, input int h1,
                           input int per, input bit push, input int tail);
    int h;
    if (push) exp_q.push_back(w);
    for (int i = 23; i >= 0; i--) begin
      h = w[i] ? h1 : h0;
      pulse(h, (i == 0 && tail > 0) ? tail : per - h);
    end
  endtask

  task automatic std_word(input logic [23:0] w);
    send_word(w, 26, 51, 80, 1'b1, 0);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_data"},  data,  32'h0);
    chk({pfx, "_valid"}, valid, 32'h0);
    chk({pfx, "_latch"}, latch, 32'h0);
    chk({pfx, "_err"},   err,   32'h0);
    chk({pfx, "_busy"},  busy,  32'h0);
    chk({pfx, "_fwd"},   fwd,   32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] w;
    reset = 1'b1;
    din   = 1'b0;
    tick(3);
    chk_outputs_zero("reset");
    reset = 1'b0;
    tick(3210);
    chk("sync_exit_latch", latch_cnt, 0);
    chk("sync_exit_err", err_cnt, 0);

    // basic word, latency and latch timing
    std_word(24'hA53CF0);
    chk("t1_busy", busy, 1);
    chk("t1_valid_cnt", valid_cnt, 1);
    chk("t1_valid_latency", valid_cyc - last_fall_cyc, 4);
    tick(3210);
    chk("t1_latch_cnt", latch_cnt, 1);
    chk("t1_latch_timing", latch_cyc - last_fall_cyc, 3202);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_busy_after_gap", busy, 0);

    // two words in a frame, pass-through of the second
    fwd_mon = 1'b1;
    fwd_phase = 1'b0;
    std_word(24'h112233);
    fwd_phase = 1'b1;
    std_word(24'h445566);
    tick(3210);
    fwd_mon = 1'b0;
    chk("t2_valid_cnt", valid_cnt, 3);
    chk("t2_latch_cnt", latch_cnt, 2);
    chk("t2_fwd_mismatch_cycles", fwd_bad, 0);
    w = 24'h445566;
    chk("t2_fwd_high_cycles", fwd_hi, $countones(w) * 51 + (24 - $countones(w)) * 26);

    // partial word then gap
    for (int i = 0; i < 10; i++) pulse((i % 2) ? 51 : 26, (i % 2) ? 29 : 54);
    chk("t3_busy_mid", busy, 1);
    tick(3210);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_valid_cnt", valid_cnt, 3);
    chk("t3_latch_cnt", latch_cnt, 2);
    chk("t3_busy", busy, 0);
    std_word(24'h5A5A5A);
    tick(3210);
    chk("t3_next_valid", valid_cnt, 4);
    chk("t3_next_latch", latch_cnt, 3);

    // glitch inside a word
    w = 24'h0000FF;
    exp_q.push_back(w);
    for (int i = 23; i >= 0; i--) begin
      pulse(w[i] ? 51 : 26, w[i] ? 29 : 54);
      if (i == 12) pulse(4, 40);
    end
    tick(3210);
    chk("t4_glitch_valid", valid_cnt, 5);
    chk("t4_glitch_err", err_cnt, 1);
    chk("t4_glitch_latch", latch_cnt, 4);

    // stuck high, then SYNC ignores a word until a gap
    pulse(150, 100);
    chk("t4_stuck_err_cnt", err_cnt, 2);
    chk("t4_stuck_err_timing", err_cyc - last_rise_cyc, 103);
    chk("t4_stuck_busy", busy, 0);
    send_word(24'h123456, 26, 51, 80, 1'b0, 0);
    tick(3210);
    chk("t4_sync_valid", valid_cnt, 5);
    chk("t4_sync_latch", latch_cnt, 4);
    chk("t4_sync_err", err_cnt, 2);
    std_word(24'h654321);
    tick(3210);
    chk("t4_recover_valid", valid_cnt, 6);
    chk("t4_recover_latch", latch_cnt, 5);

    // reset mid-word with din high through reset
    w = 24'hABCDEF;
    for (int i = 23; i >= 12; i--) pulse(w[i] ? 51 : 26, w[i] ? 29 : 54);
    chk("t5_busy_before", busy, 1);
    din = 1'b1;
    reset = 1'b1;
    #1;
    chk_outputs_zero("t5_async");
    tick(5);
    reset = 1'b0;
    tick(20);
    din = 1'b0;
    tick(30);
    for (int i = 11; i >= 0; i--) pulse(w[i] ? 51 : 26, w[i] ? 29 : 54);
    tick(3210);
    chk("t5_ignored_valid", valid_cnt, 6);
    chk("t5_ignored_err", err_cnt, 2);
    std_word(24'hC3C3C3);
    tick(3210);
    chk("t5_next_valid", valid_cnt, 7);
    chk("t5_next_latch", latch_cnt, 6);

    // width boundaries: 38 -> 0, 39 -> 1, 8 and 100 accepted
    send_word(24'h0F0F0F, 38, 39, 120, 1'b1, 0);
    send_word(24'hF0A50F, 8, 100, 160, 1'b1, 0);
    tick(3210);
    chk("t6_width_valid", valid_cnt, 9);
    chk("t6_width_err", err_cnt, 2);
    chk("t6_width_latch", latch_cnt, 7);
    pulse(101, 200);
    chk("t6_h101_err", err_cnt, 3);
    tick(3210);
    chk("t6_h101_no_latch", latch_cnt, 7);

    // gap boundaries: 3199 low continues the frame, 3200 latches
    send_word(24'h13579B, 26, 51, 80, 1'b1, 3199);
    send_word(24'h2468AC, 26, 51, 80, 1'b1, 3200);
    chk("t6_gap3199_no_latch", latch_cnt, 7);
    tick(4);
    chk("t6_gap3200_latch", latch_cnt, 8);
    chk("t6_gap3200_timing", latch_cyc - last_fall_cyc, 3202);
    chk("t6_valid_cnt", valid_cnt, 11);
    chk("t6_err_cnt", err_cnt, 3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
